fetch_control_unit: RTL and testbench

- Instruction-side counterpart of the RV32I single-cycle datapath.
- Holds the PC and presents it to instruction memory.
- Decodes the returned word into the datapath control bundle (RegWrite, ALUSrc, ALUControl, MemWrite, MemRead, MemToReg, Instruction).
- Consumes the datapath's Sign/Zero flags to resolve conditional branches. A small run/halt state machine sequences execution.

---
 rtl/fcu_pkg.sv | 59 +++++
 rtl/fcu_main_decoder.sv | 50 +++++
 rtl/fetch_control_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_control_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fcu_pkg.sv
// Shared definitions for the RV32I fetch/control unit: opcodes, ALU control
// encodings, run/halt state encoding, NOP word and decoded control bundle.
package fcu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SLTU = 4'd8
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fcu_state_e;

  typedef struct packed {
    logic      reg_write;
    logic      alu_src;
    alu_ctrl_e alu_ctrl;
    logic      mem_write;
    logic      mem_read;
    logic      mem_to_reg;
    logic      branch;
    logic      system;
    logic      illegal;
  } ctrl_t;

  // funct3 -> ALU operation shared by R-type and I-type arithmetic
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/fcu_main_decoder.sv
// Combinational main decoder: opcode/funct fields to datapath control bundle,
// plus branch/system markers and an illegal-opcode flag.
module fcu_main_decoder
  import fcu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output ctrl_t      ctrl_o
);

  // Opcode decode; unknown opcodes produce an all-zero bundle with illegal set
  always_comb begin
    ctrl_o          = '0;
    ctrl_o.alu_ctrl = ALU_ADD;
    case (opcode_i)
      OP_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_ctrl  = alu_from_funct3(funct3_i, funct7b5_i);
      end
      OP_I: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_ctrl  = alu_from_funct3(funct3_i, 1'b0);
      end
      OP_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_ctrl  = ALU_SLL;
      end
      OP_BRANCH: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.alu_ctrl = ALU_SUB;
      end
      OP_SYSTEM: ctrl_o.system  = 1'b1;
      default:   ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_control_unit.sv
// RV32I fetch/control unit: PC register, run/halt FSM, branch resolution,
// retired-instruction counter and zero-latency control decode.
// Optional feature macro: FCU_ILLEGAL_TRAP_EN (trap to HALT with Error on an
// unknown opcode or a taken branch to a target with bit1 set).
module fetch_control_unit
  import fcu_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned          PC_STEP  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Start,
  input  logic [31:0]         Instr_in,
  input  logic                Sign,
  input  logic                Zero,
  output logic [PC_WIDTH-1:0] PC,
  output logic [31:0]         Instruction,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic [3:0]          ALUControl,
  output logic                MemWrite,
  output logic                MemRead,
  output logic                MemToReg,
  output logic                Halted,
  output logic                Error,
  output logic [31:0]         Retired
);

  fcu_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         retired_q, retired_d;
  logic                error_q, error_d;

  ctrl_t               dec;
  logic                run;
  logic                br_cond;
  logic                br_taken;
  logic                trap;
  logic                we_ok;
  logic [31:0]         b_imm;
  logic [PC_WIDTH-1:0] pc_target;
  logic [PC_WIDTH-1:0] pc_seq;

  fcu_main_decoder u_dec (
    .opcode_i   (Instr_in[6:0]),
    .funct3_i   (Instr_in[14:12]),
    .funct7b5_i (Instr_in[30]),
    .ctrl_o     (dec)
  );

  assign run       = (state_q == ST_RUN);
  assign b_imm     = {{19{Instr_in[31]}}, Instr_in[31], Instr_in[7],
                      Instr_in[30:25], Instr_in[11:8], 1'b0};
  assign pc_target = pc_q + PC_WIDTH'($signed(b_imm));
  assign pc_seq    = pc_q + PC_WIDTH'(PC_STEP);

  // Branch condition from the datapath flags of the current instruction
  always_comb begin
    br_cond = 1'b0;
    case (Instr_in[14:12])
      3'b000:  br_cond = Zero;
      3'b001:  br_cond = !Zero;
      3'b100:  br_cond = Sign;
      3'b101:  br_cond = !Sign;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken = run && dec.branch && br_cond;

`ifdef FCU_ILLEGAL_TRAP_EN
  assign trap = run && (dec.illegal || (br_taken && pc_target[1]));
`else
  assign trap = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; halting instructions and traps take precedence over Start
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_RUN;
      ST_RUN:  if (dec.system || trap) state_d = ST_HALT;
      ST_HALT: if (Start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs: combinational, write enables only while running
  always_comb begin
    we_ok       = run && !trap && !dec.illegal;
    Instruction = run ? Instr_in : NOP;
    RegWrite    = we_ok && dec.reg_write;
    MemWrite    = we_ok && dec.mem_write;
    MemRead     = we_ok && dec.mem_read;
    MemToReg    = we_ok && dec.mem_to_reg;
    ALUSrc      = run && dec.alu_src;
    ALUControl  = run ? dec.alu_ctrl : ALU_ADD;
    Halted      = (state_q == ST_HALT);
    Error       = error_q;
    Retired     = retired_q;
    PC          = pc_q;
  end

  // Next PC, retired count and sticky error
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    error_d   = error_q;
    case (state_q)
      ST_RUN: begin
        if (trap) begin
          error_d = 1'b1;
        end else if (!dec.system) begin
          pc_d      = br_taken ? pc_target : pc_seq;
          retired_d = retired_q + 32'd1;
        end
      end
      ST_HALT: begin
        if (Start) begin
          pc_d    = RESET_PC;
          error_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= RESET_PC;
      retired_q <= '0;
      error_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed table-driven bench for fetch_control_unit.
module tb_fetch_control_unit;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] SUB   = 32'h40310233;
  localparam logic [31:0] SLTU  = 32'h003138B3;
  localparam logic [31:0] LW    = 32'h01412703;
  localparam logic [31:0] SW    = 32'h00112223;
  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] ADDI  = 32'h40000093; // funct3 000 with bit30 set: still add
  localparam logic [31:0] ANDI  = 32'h0FF07093;
  localparam logic [31:0] ORR   = 32'h0020E1B3;
  localparam logic [31:0] XORR  = 32'h0020C1B3;
  localparam logic [31:0] SRLR  = 32'h0020D1B3;
  localparam logic [31:0] SLLR  = 32'h002091B3;
  localparam logic [31:0] SLTR  = 32'h0020A1B3;
  localparam logic [31:0] BEQ16 = 32'h00000863;
  localparam logic [31:0] BNE16 = 32'h00001863;
  localparam logic [31:0] BGE16 = 32'h00005863;
  localparam logic [31:0] BLTM8 = 32'hFE004CE3;
  localparam logic [31:0] BR010 = 32'h00002863;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] ILL   = 32'hFFFFFFFF;
`ifdef FCU_ILLEGAL_TRAP_EN
  localparam logic [31:0] BEQ2  = 32'h00000163;
`endif

  // {RegWrite, ALUSrc, MemWrite, MemRead, MemToReg}
  localparam logic [4:0] EN_0  = 5'b00000;
  localparam logic [4:0] EN_R  = 5'b10000;
  localparam logic [4:0] EN_I  = 5'b11000;
  localparam logic [4:0] EN_LD = 5'b11011;
  localparam logic [4:0] EN_ST = 5'b01100;

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic        sign;
    logic        zero;
    logic [31:0] pc;
    logic        fwd;
    logic [4:0]  en;
    logic [3:0]  alu;
    logic        halt;
    logic        err;
    logic [31:0] ret;
  } vec_t;

  logic        CLK, RST, Start, Sign, Zero;
  logic [31:0] Instr_in;
  logic [31:0] PC, Instruction, Retired;
  logic        RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Halted, Error;
  logic [3:0]  ALUControl;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_control_unit #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Start       (Start),
    .Instr_in    (Instr_in),
    .Sign        (Sign),
    .Zero        (Zero),
    .PC          (PC),
    .Instruction (Instruction),
    .RegWrite    (RegWrite),
    .ALUSrc      (ALUSrc),
    .ALUControl  (ALUControl),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .MemToReg    (MemToReg),
    .Halted      (Halted),
    .Error       (Error),
    .Retired     (Retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic rst, input logic start, input logic [31:0] instr,
                              input logic sign, input logic zero, input logic [31:0] pc,
                              input logic fwd, input logic [4:0] en, input logic [3:0] alu,
                              input logic halt, input logic err, input logic [31:0] ret);
    vec_t v;
    v.rst = rst; v.start = start; v.instr = instr; v.sign = sign; v.zero = zero;
    v.pc = pc; v.fwd = fwd; v.en = en; v.alu = alu; v.halt = halt; v.err = err; v.ret = ret;
    return v;
  endfunction

  // Drive one cycle of inputs after the falling edge, check, then advance a clock
  task automatic apply(input vec_t v, input string name);
    logic [31:0] exp_instr;
    logic [4:0]  act_en;
    RST = v.rst; Start = v.start; Instr_in = v.instr; Sign = v.sign; Zero = v.zero;
    #1;
    exp_instr = v.fwd ? v.instr : NOP_W;
    act_en    = {RegWrite, ALUSrc, MemWrite, MemRead, MemToReg};
    checks++;
    if (PC !== v.pc || Instruction !== exp_instr || act_en !== v.en || ALUControl !== v.alu ||
        Halted !== v.halt || Error !== v.err || Retired !== v.ret) begin
      errors++;
      $display("FAIL %s: got pc=%h ins=%h en=%b alu=%0d halt=%b err=%b ret=%0d; want pc=%h ins=%h en=%b alu=%0d halt=%b err=%b ret=%0d",
               name, PC, Instruction, act_en, ALUControl, Halted, Error, Retired,
               v.pc, exp_instr, v.en, v.alu, v.halt, v.err, v.ret);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  vec_t tbl[$];

  initial begin
    RST = 1'b1; Start = 1'b0; Instr_in = ADD; Sign = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    //                  rst st instr  S  Z  pc        fwd en     alu   H  E  ret
    tbl.push_back(mk(0, 0, ADD,   0, 0, 32'd0,  0, EN_0,  4'd0, 0, 0, 32'd0));  // reset state, IDLE
    tbl.push_back(mk(0, 1, ADD,   0, 0, 32'd0,  0, EN_0,  4'd0, 0, 0, 32'd0));  // Start
    tbl.push_back(mk(0, 0, ADD,   0, 0, 32'd0,  1, EN_R,  4'd0, 0, 0, 32'd0));
    tbl.push_back(mk(0, 0, SUB,   0, 0, 32'd4,  1, EN_R,  4'd1, 0, 0, 32'd1));
    tbl.push_back(mk(0, 0, SLTU,  0, 0, 32'd8,  1, EN_R,  4'd8, 0, 0, 32'd2));
    tbl.push_back(mk(0, 0, LW,    0, 0, 32'd12, 1, EN_LD, 4'd0, 0, 0, 32'd3));
    tbl.push_back(mk(0, 0, SW,    0, 0, 32'd16, 1, EN_ST, 4'd0, 0, 0, 32'd4));
    tbl.push_back(mk(0, 0, LUI,   0, 0, 32'd20, 1, EN_I,  4'd4, 0, 0, 32'd5));
    tbl.push_back(mk(0, 0, ADDI,  0, 0, 32'd24, 1, EN_I,  4'd0, 0, 0, 32'd6));
    tbl.push_back(mk(0, 0, ANDI,  0, 0, 32'd28, 1, EN_I,  4'd2, 0, 0, 32'd7));
    tbl.push_back(mk(0, 0, ORR,   0, 0, 32'd32, 1, EN_R,  4'd3, 0, 0, 32'd8));
    tbl.push_back(mk(0, 0, XORR,  0, 0, 32'd36, 1, EN_R,  4'd6, 0, 0, 32'd9));
    tbl.push_back(mk(0, 0, SRLR,  0, 0, 32'd40, 1, EN_R,  4'd7, 0, 0, 32'd10));
    tbl.push_back(mk(0, 0, SLLR,  0, 0, 32'd44, 1, EN_R,  4'd4, 0, 0, 32'd11));
    tbl.push_back(mk(0, 1, SLTR,  0, 0, 32'd48, 1, EN_R,  4'd5, 0, 0, 32'd12)); // Start ignored in RUN
    tbl.push_back(mk(0, 0, BEQ16, 0, 0, 32'd52, 1, EN_0,  4'd1, 0, 0, 32'd13)); // not taken -> 56
    tbl.push_back(mk(0, 0, BEQ16, 0, 1, 32'd56, 1, EN_0,  4'd1, 0, 0, 32'd14)); // taken -> 72
    tbl.push_back(mk(0, 0, BLTM8, 1, 0, 32'd72, 1, EN_0,  4'd1, 0, 0, 32'd15)); // taken -> 64
    tbl.push_back(mk(0, 0, BNE16, 0, 1, 32'd64, 1, EN_0,  4'd1, 0, 0, 32'd16)); // not taken -> 68
    tbl.push_back(mk(0, 0, BGE16, 0, 0, 32'd68, 1, EN_0,  4'd1, 0, 0, 32'd17)); // taken -> 84
    tbl.push_back(mk(0, 0, BLTM8, 0, 0, 32'd84, 1, EN_0,  4'd1, 0, 0, 32'd18)); // not taken -> 88
    tbl.push_back(mk(0, 1, ECALL, 0, 0, 32'd88, 1, EN_0,  4'd0, 0, 0, 32'd19)); // ecall beats Start
    tbl.push_back(mk(0, 0, ADD,   0, 0, 32'd88, 0, EN_0,  4'd0, 1, 0, 32'd19)); // HALT holds
    tbl.push_back(mk(0, 1, ADD,   0, 0, 32'd88, 0, EN_0,  4'd0, 1, 0, 32'd19)); // restart -> PC 0

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef FCU_ILLEGAL_TRAP_EN
    apply(mk(0, 0, ILL,   0, 0, 32'd0, 1, EN_0, 4'd0, 0, 0, 32'd19), "illegal_trap");
    apply(mk(0, 1, ADD,   0, 0, 32'd0, 0, EN_0, 4'd0, 1, 1, 32'd19), "trap_halted");
    apply(mk(0, 0, BEQ2,  0, 1, 32'd0, 1, EN_0, 4'd1, 0, 0, 32'd19), "misaligned_branch");
    apply(mk(0, 1, ADD,   0, 0, 32'd0, 0, EN_0, 4'd0, 1, 1, 32'd19), "misaligned_halted");
    apply(mk(0, 0, ADD,   0, 0, 32'd0, 1, EN_R, 4'd0, 0, 0, 32'd19), "restart_clears_err");
    apply(mk(1, 1, ADD,   0, 0, 32'd4, 1, EN_R, 4'd0, 0, 0, 32'd20), "rst_mid_run");
`else
    apply(mk(0, 0, ILL,   0, 0, 32'd0, 1, EN_0, 4'd0, 0, 0, 32'd19), "illegal_as_nop");
    apply(mk(0, 0, BR010, 0, 1, 32'd4, 1, EN_0, 4'd1, 0, 0, 32'd20), "branch_f3_010");
    apply(mk(0, 0, ADD,   0, 0, 32'd8, 1, EN_R, 4'd0, 0, 0, 32'd21), "after_nop");
    apply(mk(1, 1, ADD,   0, 0, 32'd12, 1, EN_R, 4'd0, 0, 0, 32'd22), "rst_mid_run");
`endif
    apply(mk(0, 0, ADD, 0, 0, 32'd0, 0, EN_0, 4'd0, 0, 0, 32'd0), "post_rst_idle");
    apply(mk(0, 0, LW,  0, 0, 32'd0, 0, EN_0, 4'd0, 0, 0, 32'd0), "idle_holds");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
